// File: rtl/axi_pipeline_rr_arbiter.sv
// Packet-granular round-robin arbiter that shares one valid/ready sink between INPUTS requesters.
// The grant is held from a packet's first beat until its last beat is accepted. The output is one registered stage.
module axi_pipeline_rr_arbiter #(
    parameter  int INPUTS = 4,
    parameter  int WIDTH  = 32,
    localparam int IDX_W  = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [INPUTS*WIDTH-1:0] src_data,
    input  logic [INPUTS-1:0]       src_valid,
    input  logic [INPUTS-1:0]       src_last,
    output logic [INPUTS-1:0]       src_ready,
    output logic [WIDTH-1:0]        sink_data,
    output logic                    sink_valid,
    output logic                    sink_last,
    input  logic                    sink_ready,
    output logic [INPUTS-1:0]       grant,
    output logic                    busy
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t             state;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;
    logic [IDX_W:0]     pos;
    logic               can_load;
    logic               accept;
    logic               sel_valid;
    logic               sel_last;
    logic [WIDTH-1:0]   sel_data;

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        grant     = '0;
        for (int i = 0; i < INPUTS; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_valid = src_valid[i];
                sel_last  = src_last[i];
                sel_data  = src_data[i*WIDTH +: WIDTH];
                grant[i]  = (state == LOCKED);
            end
        end
    end

    assign busy      = (state == LOCKED);
    assign can_load  = !sink_valid || sink_ready;
    assign src_ready = can_load ? grant : '0;
    assign accept    = busy && can_load && sel_valid;

    // Scan from rr_ptr upward with an explicit modulo wrap, so non-power-of-two INPUTS works.
    // NOTE: blocking assignments here are intentional; pos is a scratch value reused on each iteration.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pos        = '0;
        for (int i = 0; i < INPUTS; i++) begin
            pos = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (pos >= (IDX_W+1)'(INPUTS))
                pos = pos - (IDX_W+1)'(INPUTS);
            if (!pick_found && src_valid[pos[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = pos[IDX_W-1:0];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant_idx <= '0;
            rr_ptr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state     <= LOCKED;
                        grant_idx <= pick_idx;
                    end
                end
                LOCKED: begin
                    if (accept && sel_last) begin
                        state  <= IDLE;
                        rr_ptr <= (grant_idx == IDX_W'(INPUTS-1)) ? '0 : grant_idx + IDX_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the data register is reset as well, because a mid-packet reset must clear every visible output at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sink_valid <= 1'b0;
            sink_data  <= '0;
            sink_last  <= 1'b0;
        end else if (can_load) begin
            sink_valid <= accept;
            if (accept) begin
                sink_data <= sel_data;
                sink_last <= sel_last;
            end
        end
    end

endmodule

// File: tb/tb_axi_pipeline_rr_arbiter.sv
// Self-checking bench for axi_pipeline_rr_arbiter: a vector table plus directed multi-cycle sequences.
module tb_axi_pipeline_rr_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic [N*W-1:0] src_data;
    logic [N-1:0]   src_valid;
    logic [N-1:0]   src_last;
    logic [N-1:0]   src_ready;
    logic [W-1:0]   sink_data;
    logic           sink_valid;
    logic           sink_last;
    logic           sink_ready;
    logic [N-1:0]   grant;
    logic           busy;

    int checks = 0;
    int errors = 0;

    axi_pipeline_rr_arbiter #(.INPUTS(N), .WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .src_data   (src_data),
        .src_valid  (src_valid),
        .src_last   (src_last),
        .src_ready  (src_ready),
        .sink_data  (sink_data),
        .sink_valid (sink_valid),
        .sink_last  (sink_last),
        .sink_ready (sink_ready),
        .grant      (grant),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [N-1:0]   valid;
        logic [N-1:0]   last;
        logic [N*W-1:0] data;
        logic           sr;
        logic           ev;
        logic [W-1:0]   ed;
        logic           el;
        logic [N-1:0]   eg;
        logic [N-1:0]   erdy;
        logic           eb;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [N*W-1:0] put(input int who, input logic [W-1:0] d);
        logic [N*W-1:0] r;
        r = '0;
        r[who*W +: W] = d;
        return r;
    endfunction

    task automatic add(input logic [N-1:0] v, input logic [N-1:0] l, input int who, input logic [W-1:0] d,
                       input logic sr, input logic ev, input logic [W-1:0] ed, input logic el,
                       input logic [N-1:0] eg, input logic [N-1:0] erdy, input logic eb);
        vec_t t;
        t.valid = v;  t.last = l;  t.data = put(who, d);  t.sr = sr;
        t.ev = ev;    t.ed = ed;   t.el = el;  t.eg = eg; t.erdy = erdy; t.eb = eb;
        vecs.push_back(t);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        src_valid  = '0;
        src_last   = '0;
        src_data   = '0;
        sink_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Generic requester driver: per-requester packet count/length, start cycle and an optional valid gap.
    int npk[N], plen[N], start[N], gap_at[N], gap_len[N];
    int sent[N], gleft[N];
    logic [W-1:0] got[$];
    int got_cyc[$];
    int r1_viol;

    task automatic clear_cfg();
        for (int i = 0; i < N; i++) begin
            npk[i] = 0; plen[i] = 1; start[i] = 0; gap_at[i] = -1; gap_len[i] = 0;
        end
    endtask

    task automatic run(input int budget);
        int total;
        logic act;
        total = 0;
        for (int i = 0; i < N; i++) begin
            sent[i]  = 0;
            gleft[i] = gap_len[i];
            total   += npk[i] * plen[i];
        end
        got.delete();
        got_cyc.delete();
        r1_viol = 0;
        for (int c = 0; c < budget && got.size() < total; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                act = (c >= start[i]) && (sent[i] < npk[i] * plen[i]);
                if (act && sent[i] == gap_at[i] && gleft[i] > 0) begin
                    act = 1'b0;
                    gleft[i]--;
                end
                src_valid[i] = act;
                src_last[i]  = act && ((sent[i] % plen[i]) == plen[i] - 1);
                src_data[i*W +: W] = W'(i + (sent[i] << 8));
            end
            sink_ready = 1'b1;
            #1;
            if (sink_valid) begin
                got.push_back(sink_data);
                got_cyc.push_back(c);
            end
            if (src_ready[1] && sent[2] > 0 && sent[2] < npk[2] * plen[2])
                r1_viol++;
            for (int i = 0; i < N; i++)
                if (src_valid[i] && src_ready[i])
                    sent[i]++;
        end
        @(negedge clk);
        src_valid = '0;
        src_last  = '0;
    endtask

    task automatic check_seq(input string tag, input logic [W-1:0] exp[$]);
        check({tag, "_count"}, 64'(got.size()), 64'(exp.size()));
        for (int k = 0; k < exp.size() && k < got.size(); k++)
            check($sformatf("%s_beat%0d", tag, k), 64'(got[k]), 64'(exp[k]));
    endtask

    initial begin
        logic [W-1:0] exp_q[$];
        int bad;

        // Requester 0 three-beat packet, then requester 1 packet with 5 cycles of sink backpressure.
        add(4'b0001, 4'b0000, 0, 32'hA1, 1, 0, 32'h0,  0, 4'b0000, 4'b0000, 0);
        add(4'b0001, 4'b0000, 0, 32'hA1, 1, 0, 32'h0,  0, 4'b0001, 4'b0001, 1);
        add(4'b0001, 4'b0000, 0, 32'hA2, 1, 1, 32'hA1, 0, 4'b0001, 4'b0001, 1);
        add(4'b0001, 4'b0001, 0, 32'hA3, 1, 1, 32'hA2, 0, 4'b0001, 4'b0001, 1);
        add(4'b0000, 4'b0000, 0, 32'h0,  1, 1, 32'hA3, 1, 4'b0000, 4'b0000, 0);
        add(4'b0000, 4'b0000, 0, 32'h0,  1, 0, 32'h0,  0, 4'b0000, 4'b0000, 0);
        add(4'b0010, 4'b0000, 1, 32'hB1, 1, 0, 32'h0,  0, 4'b0000, 4'b0000, 0);
        add(4'b0010, 4'b0000, 1, 32'hB1, 1, 0, 32'h0,  0, 4'b0010, 4'b0010, 1);
        for (int k = 0; k < 5; k++)
            add(4'b0010, 4'b0000, 1, 32'hB2, 0, 1, 32'hB1, 0, 4'b0010, 4'b0000, 1);
        add(4'b0010, 4'b0000, 1, 32'hB2, 1, 1, 32'hB1, 0, 4'b0010, 4'b0010, 1);
        add(4'b0010, 4'b0010, 1, 32'hB3, 1, 1, 32'hB2, 0, 4'b0010, 4'b0010, 1);
        add(4'b0000, 4'b0000, 0, 32'h0,  1, 1, 32'hB3, 1, 4'b0000, 4'b0000, 0);
        add(4'b0000, 4'b0000, 0, 32'h0,  1, 0, 32'h0,  0, 4'b0000, 4'b0000, 0);

        do_reset();
        #1;
        check("reset_state", 64'({sink_valid, sink_data, sink_last, grant, src_ready, busy}), 64'(0));

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            src_valid  = vecs[k].valid;
            src_last   = vecs[k].last;
            src_data   = vecs[k].data;
            sink_ready = vecs[k].sr;
            #1;
            check($sformatf("vec%0d", k),
                  64'({sink_valid, sink_valid ? sink_data : 32'h0, sink_valid ? sink_last : 1'b0,
                       grant, src_ready, busy}),
                  64'({vecs[k].ev, vecs[k].ev ? vecs[k].ed : 32'h0, vecs[k].ev ? vecs[k].el : 1'b0,
                       vecs[k].eg, vecs[k].erdy, vecs[k].eb}));
        end

        // Asynchronous reset mid-packet, then requester 3 alone after release.
        do_reset();
        src_valid = 4'b0010; src_last = 4'b0000; src_data = put(1, 32'hC1);
        @(negedge clk);
        @(negedge clk);
        src_data = put(1, 32'hC2);
        #1;
        check("pre_reset_sink", 64'({sink_valid, sink_data}), 64'({1'b1, 32'hC1}));
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_clear", 64'({sink_valid, sink_data, sink_last, grant, src_ready, busy}), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        src_valid = 4'b1000; src_last = 4'b1000; src_data = put(3, 32'hD3);
        #1;
        check("post_reset_idle", 64'({grant, busy}), 64'(0));
        @(negedge clk);
        #1;
        check("post_reset_grant3", 64'({grant, src_ready, busy}), 64'({4'b1000, 4'b1000, 1'b1}));
        @(negedge clk);
        src_valid = '0; src_last = '0;

        // Round robin with every requester holding valid; 1-beat packets, order restarts at 0 after reset.
        do_reset();
        clear_cfg();
        npk[0] = 2; npk[1] = 2; npk[2] = 1; npk[3] = 1;
        run(60);
        exp_q = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h100, 32'h101};
        check_seq("rr", exp_q);
        bad = 0;
        for (int k = 0; k + 1 < got_cyc.size(); k++)
            if (got_cyc[k+1] - got_cyc[k] != 2) bad++;
        check("rr_bubbles", 64'(bad), 64'(0));

        // Requester 2 four-beat packet, requester 1 raises valid mid-packet.
        do_reset();
        clear_cfg();
        npk[2] = 1; plen[2] = 4;
        npk[1] = 1; start[1] = 2;
        run(60);
        exp_q = '{32'h2, 32'h102, 32'h202, 32'h302, 32'h1};
        check_seq("lock", exp_q);
        check("lock_ready1_low", 64'(r1_viol), 64'(0));

        // Granted requester drops valid for 3 cycles mid-packet while others wait.
        do_reset();
        clear_cfg();
        npk[0] = 1; plen[0] = 3; gap_at[0] = 1; gap_len[0] = 3;
        npk[1] = 1; npk[2] = 1;
        run(60);
        exp_q = '{32'h0, 32'h100, 32'h200, 32'h1, 32'h2};
        check_seq("gap", exp_q);
        if (got_cyc.size() >= 2)
            check("gap_cycles", 64'(got_cyc[1] - got_cyc[0]), 64'(4));
        else
            check("gap_cycles", 64'(got_cyc.size()), 64'(2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
